// File: rtl/sfq_and_driver.sv
// Stimulus driver for a toggle-encoded RSFQ AND cell: sequences a/b/clk pulses with
// programmed spacing, watches the cell's out line and reports result and error flags.
module sfq_and_driver #(
  parameter int DATA_GAP  = 2,
  parameter int SETUP_CYC = 3,
  parameter int OUT_WIN   = 6,
  parameter int HOLD_CYC  = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic             req_a,
  input  logic             req_b,
  output logic             req_ready,
  output logic             sfq_a,
  output logic             sfq_b,
  output logic             sfq_clk,
  input  logic             sfq_out,
  output logic             result_valid,
  output logic             result_bit,
  output logic             result_err,
  output logic             spurious_err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] out_pulse_cnt
);

  typedef enum logic [3:0] {
    IDLE, SEND_A, GAP_AB, SEND_B, GAP_CLK, SEND_CLK, WAIT_OUT, REPORT, HOLD
  } state_t;

  state_t      state, state_nx;
  logic [15:0] cnt, cnt_nx;
  logic        lat_a, lat_b;
  logic        sync1, sync2, prev;
  logic        det;
  logic [1:0]  pcnt;

  // Any edge on the synchronised out line is one pulse.
  assign det       = sync2 ^ prev;
  assign req_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Shared down-counter: loaded with (cycles-1) on entry, state exits when it hits 0.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE:     if (req_valid) state_nx = SEND_A;
      SEND_A:   begin state_nx = GAP_AB;   cnt_nx = 16'(DATA_GAP - 1);  end
      GAP_AB:   if (cnt == '0) state_nx = SEND_B;   else cnt_nx = cnt - 16'd1;
      SEND_B:   begin state_nx = GAP_CLK;  cnt_nx = 16'(SETUP_CYC - 1); end
      GAP_CLK:  if (cnt == '0) state_nx = SEND_CLK; else cnt_nx = cnt - 16'd1;
      SEND_CLK: begin state_nx = WAIT_OUT; cnt_nx = 16'(OUT_WIN - 1);   end
      WAIT_OUT: if (cnt == '0) state_nx = REPORT;   else cnt_nx = cnt - 16'd1;
      REPORT: begin
        if (HOLD_CYC == 0) state_nx = IDLE;
        else begin
          state_nx = HOLD;
          cnt_nx   = 16'(HOLD_CYC - 1);
        end
      end
      HOLD:     if (cnt == '0) state_nx = IDLE;     else cnt_nx = cnt - 16'd1;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_a         <= 1'b0;
      lat_b         <= 1'b0;
      sfq_a         <= 1'b0;
      sfq_b         <= 1'b0;
      sfq_clk       <= 1'b0;
      sync1         <= 1'b0;
      sync2         <= 1'b0;
      prev          <= 1'b0;
      pcnt          <= 2'd0;
      result_valid  <= 1'b0;
      result_bit    <= 1'b0;
      result_err    <= 1'b0;
      spurious_err  <= 1'b0;
      out_pulse_cnt <= '0;
    end else begin
      sync1 <= sfq_out;
      sync2 <= sync1;
      prev  <= sync2;
      if (state == IDLE && req_valid) begin
        lat_a <= req_a;
        lat_b <= req_b;
      end
      // Skipped pulses still use their slot so latency is data independent.
      if (state == SEND_A   && lat_a) sfq_a <= ~sfq_a;
      if (state == SEND_B   && lat_b) sfq_b <= ~sfq_b;
      if (state == SEND_CLK)          sfq_clk <= ~sfq_clk;
      if (state == SEND_CLK)                          pcnt <= 2'd0;
      else if (state == WAIT_OUT && det && pcnt != 2'd2) pcnt <= pcnt + 2'd1;
      result_valid <= (state == REPORT);
      if (state == REPORT) begin
        result_bit <= (pcnt == 2'd1);
        result_err <= (pcnt != {1'b0, lat_a & lat_b});
      end
      // A new detection beats a same-cycle clear.
      if (det && state != WAIT_OUT) spurious_err <= 1'b1;
      else if (err_clr)             spurious_err <= 1'b0;
      if (det) out_pulse_cnt <= out_pulse_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_sfq_and_driver.sv
// Bench for sfq_and_driver: behavioural AND-cell model, table-driven and random requests
// checked against timeline arithmetic, plus spurious, back-to-back and reset sequences.
module tb_sfq_and_driver;
  localparam int DG = 2, SC = 3, OW = 6, HC = 2;
  localparam int T_A   = 1;
  localparam int T_B   = 2 + DG;
  localparam int T_CLK = 3 + DG + SC;
  localparam int T_RV  = 4 + DG + SC + OW;
  localparam int T_RDY = T_RV + HC;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_a = 1'b0, req_b = 1'b0, err_clr = 1'b0;
  logic        req_ready, sfq_a, sfq_b, sfq_clk, sfq_out;
  logic        result_valid, result_bit, result_err, spurious_err;
  logic [15:0] out_pulse_cnt;

  logic        cell_out, tb_inj = 1'b0;
  int          cell_mode = 0;          // 0 = correct AND, 1 = always fires, 2 = never fires
  logic        a_seen, b_seen, pa, pb, pc;
  int          cyc = 0;
  int          n_pass = 0, n_tot = 0;

  assign sfq_out = cell_out ^ tb_inj;

  sfq_and_driver #(.DATA_GAP(DG), .SETUP_CYC(SC), .OUT_WIN(OW), .HOLD_CYC(HC), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .sfq_a(sfq_a), .sfq_b(sfq_b), .sfq_clk(sfq_clk), .sfq_out(sfq_out),
    .result_valid(result_valid), .result_bit(result_bit), .result_err(result_err),
    .spurious_err(spurious_err), .err_clr(err_clr), .out_pulse_cnt(out_pulse_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Toggle-encoded AND cell; state is discarded while reset is asserted.
  always @(sfq_a, sfq_b, sfq_clk, rst_n) begin
    if (rst_n !== 1'b1) begin
      a_seen = 1'b0; b_seen = 1'b0; cell_out = 1'b0;
    end else begin
      if (sfq_a !== pa) a_seen = 1'b1;
      if (sfq_b !== pb) b_seen = 1'b1;
      if (sfq_clk !== pc) begin
        if (cell_mode == 1 || (cell_mode == 0 && a_seen && b_seen)) cell_out = ~cell_out;
        a_seen = 1'b0; b_seen = 1'b0;
      end
    end
    pa = sfq_a; pb = sfq_b; pc = sfq_clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // One request from acceptance to idle; times are edges relative to acceptance.
  task automatic run_req(input logic a, input logic b, input int mode, input int inj,
                         input logic e_bit, input logic e_err, input int e_np);
    int t0, ta, tb, tc, tv, na, nb, nc, nv, w, r16, r17;
    logic la, lb, lc, rb, re;
    logic [15:0] c0;
    cell_mode = mode;
    w = 0;
    while (!req_ready && w < 50) begin @(negedge clk); w++; end
    if (!req_ready) begin chk("ready_timeout", 0, 1); return; end
    req_valid = 1'b1; req_a = a; req_b = b;
    la = sfq_a; lb = sfq_b; lc = sfq_clk; c0 = out_pulse_cnt;
    ta = -1; tb = -1; tc = -1; tv = -1; na = 0; nb = 0; nc = 0; nv = 0;
    rb = 1'b0; re = 1'b0; r16 = -1; r17 = -1;
    @(negedge clk);
    t0 = cyc; req_valid = 1'b0;
    for (int i = 1; i <= T_RDY + 3; i++) begin
      @(negedge clk);
      if (cyc - t0 != i) chk("cycle_align", cyc - t0, i);
      if (sfq_a   != la) begin ta = i; na++; la = sfq_a;   end
      if (sfq_b   != lb) begin tb = i; nb++; lb = sfq_b;   end
      if (sfq_clk != lc) begin tc = i; nc++; lc = sfq_clk; end
      if (result_valid) begin tv = i; nv++; rb = result_bit; re = result_err; end
      if (i == T_RDY - 1) r16 = int'(req_ready);
      if (i == T_RDY)     r17 = int'(req_ready);
      if (inj != 0 && i == inj) tb_inj = ~tb_inj;
    end
    chk("a_edge",   ta, a ? T_A : -1);   chk("a_count", na, int'(a));
    chk("b_edge",   tb, b ? T_B : -1);   chk("b_count", nb, int'(b));
    chk("clk_edge", tc, T_CLK);          chk("clk_count", nc, 1);
    chk("rv_edge",  tv, T_RV);           chk("rv_count", nv, 1);
    chk("result_bit", int'(rb), int'(e_bit));
    chk("result_err", int'(re), int'(e_err));
    chk("bit_held", int'(result_bit), int'(e_bit));
    chk("ready_before", r16, 0);         chk("ready_back", r17, 1);
    chk("pulse_delta", int'(out_pulse_cnt - c0), e_np);
    chk("no_spurious", int'(spurious_err), 0);
  endtask

  typedef struct {
    logic a, b; int mode, inj; logic e_bit, e_err; int e_np;
  } vec_t;

  initial begin
    vec_t vt[$];
    int   acc[4];
    logic [1:0] pairs[4];
    int   k, w, np, mode, inj;
    logic a, b;
    logic [15:0] c0;

    vt.push_back('{1'b1, 1'b1, 0,  0, 1'b1, 1'b0, 1});
    vt.push_back('{1'b1, 1'b0, 0,  0, 1'b0, 1'b0, 0});
    vt.push_back('{1'b0, 1'b1, 0,  0, 1'b0, 1'b0, 0});
    vt.push_back('{1'b0, 1'b0, 1,  0, 1'b1, 1'b1, 1});
    vt.push_back('{1'b1, 1'b1, 2,  0, 1'b0, 1'b1, 0});
    vt.push_back('{1'b1, 1'b1, 0, 11, 1'b0, 1'b1, 2});
    vt.push_back('{1'b0, 1'b0, 0, 11, 1'b1, 1'b1, 1});

    // Reset state
    #12;
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_lines", int'({sfq_a, sfq_b, sfq_clk}), 0);
    chk("rst_result", int'({result_valid, result_bit, result_err, spurious_err}), 0);
    chk("rst_cnt", int'(out_pulse_cnt), 0);
    @(negedge clk); rst_n = 1'b1; @(negedge clk);

    foreach (vt[i]) run_req(vt[i].a, vt[i].b, vt[i].mode, vt[i].inj,
                            vt[i].e_bit, vt[i].e_err, vt[i].e_np);

    // Random requests against the cell/window model
    for (int i = 0; i < 16; i++) begin
      a = 1'($urandom_range(0, 1)); b = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 2);
      inj  = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 11) : 0;
      np   = ((mode == 1) ? 1 : (mode == 2) ? 0 : int'(a & b)) + (inj != 0 ? 1 : 0);
      run_req(a, b, mode, inj, np == 1, np != int'(a & b), np);
    end

    // Out pulse while idle, then clear, then clear racing a fresh detection
    cell_mode = 0;
    c0 = out_pulse_cnt;
    tb_inj = ~tb_inj;
    repeat (3) @(negedge clk);
    chk("spur_set", int'(spurious_err), 1);
    chk("spur_cnt", int'(out_pulse_cnt - c0), 1);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    chk("spur_clr", int'(spurious_err), 0);
    tb_inj = ~tb_inj; err_clr = 1'b1;
    repeat (3) @(negedge clk);
    err_clr = 1'b0;
    chk("spur_set_wins", int'(spurious_err), 1);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    chk("spur_clr2", int'(spurious_err), 0);

    // Back-to-back with req_valid held high
    rst_n = 1'b0; tb_inj = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);
    pairs[0] = 2'b11; pairs[1] = 2'b11; pairs[2] = 2'b01; pairs[3] = 2'b11;
    req_valid = 1'b1; {req_a, req_b} = pairs[0]; k = 0; w = 0;
    while (k < 4 && w < 200) begin
      if (req_ready) begin
        acc[k] = cyc + 1; k++;
        @(negedge clk);
        if (k < 4) {req_a, req_b} = pairs[k];
      end else @(negedge clk);
      w++;
    end
    req_valid = 1'b0;
    chk("b2b_accepts", k, 4);
    for (int i = 1; i < 4; i++) chk("b2b_spacing", acc[i] - acc[i-1], T_RDY + 1);
    repeat (T_RDY + 4) @(negedge clk);
    chk("b2b_clk_line", int'(sfq_clk), 0);
    chk("b2b_a_line", int'(sfq_a), 1);
    chk("b2b_b_line", int'(sfq_b), 0);
    chk("b2b_cnt", int'(out_pulse_cnt), 3);

    // Reset in the middle of a request
    req_valid = 1'b1; req_a = 1'b1; req_b = 1'b1;
    @(negedge clk); req_valid = 1'b0;
    repeat (5) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b0; tb_inj = 1'b0;
    #1;
    chk("mid_rst_ready", int'(req_ready), 1);
    chk("mid_rst_lines", int'({sfq_a, sfq_b, sfq_clk}), 0);
    chk("mid_rst_result", int'({result_valid, result_bit, result_err, spurious_err}), 0);
    chk("mid_rst_cnt", int'(out_pulse_cnt), 0);
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
    run_req(1'b1, 1'b1, 0, 0, 1'b1, 1'b0, 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule
